// File: rtl/multiplexeur_rr_stream.sv
// multiplexeur_rr_stream: N-channel valid/ready stream mux with round-robin or
// fixed-priority arbitration, forced-select override and a one-entry output register.
module multiplexeur_rr_stream #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 2,
  parameter int MODE = 0,
  localparam int SELW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      force_en,
  input  logic [SELW-1:0]           force_sel,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  input  logic                      out_ready
);
  logic [CHANNELS-1:0] w_req;
  logic [SELW-1:0]     w_gnt, w_idx;
  logic                w_found, w_load_ok, w_xfer;
  logic                r_valid;
  logic [WIDTH-1:0]    r_data;
  logic [SELW-1:0]     r_sel, r_last;
  // An out-of-range force_sel matches no channel, so nothing is requested.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < CHANNELS; i++)
      w_req[i] = in_valid[i] && (!force_en || 32'(force_sel) == i);
  end
  // Scan from the farthest candidate to the nearest so the nearest match wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      w_idx = SELW'(MODE == 1 ? k - 1 : (int'(r_last) + k) % CHANNELS);
      if (w_req[w_idx]) begin
        w_found = 1'b1;
        w_gnt = w_idx;
      end
    end
  end
  assign w_load_ok = rst_n && (!r_valid || out_ready);
  assign w_xfer    = w_found && w_load_ok;
  assign in_ready  = w_xfer ? (CHANNELS'(1) << w_gnt) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_last  <= SELW'(CHANNELS - 1);
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= in_data[w_gnt*WIDTH +: WIDTH];
      r_sel   <= w_gnt;
      r_last  <= w_gnt;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;
endmodule
